// File: rtl/coin_lane_manager.sv
// Falling-coin slot manager: N independent lanes spawned by valid/ready, collected
// in the hit window under the player, flashed on collect, rendered per pixel.
module coin_lane_manager #(
    parameter int N_LANES      = 3,
    parameter int LANE_IDX_W   = 2,
    parameter int Y_W          = 10,
    parameter int COIN_SIZE    = 32,
    parameter int LANE_X0      = 160,
    parameter int LANE_PITCH   = 160,
    parameter int SPAWN_Y      = 0,
    parameter int SPEED        = 4,
    parameter int HIT_Y_MIN    = 400,
    parameter int HIT_Y_MAX    = 440,
    parameter int BOTTOM_Y     = 480,
    parameter int FLASH_FRAMES = 8,
    parameter int SCORE_W      = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_tick,
    input  logic                  i_spawn_valid,
    input  logic [LANE_IDX_W-1:0] i_spawn_lane,
    output logic                  o_spawn_ready,
    input  logic [LANE_IDX_W-1:0] i_player_lane,
    input  logic [15:0]           i_x,
    input  logic [15:0]           i_y,
    output logic [7:0]            o_red,
    output logic [7:0]            o_green,
    output logic [7:0]            o_blue,
    output logic                  o_sprite_hit,
    output logic [N_LANES-1:0]    o_in_position,
    output logic [N_LANES-1:0]    o_active,
    output logic                  o_collect,
    output logic                  o_miss,
    output logic [SCORE_W-1:0]    o_score
);
    // state | meaning
    // IDLE  | slot empty, accepts a spawn
    // FALL  | coin descending SPEED px per frame
    // FLASH | collected, blinking until the flash counter expires

    localparam int                 FLASH_W   = $clog2(FLASH_FRAMES + 1);
    localparam logic [Y_W-1:0]     HIT_MIN   = Y_W'(HIT_Y_MIN);
    localparam logic [Y_W-1:0]     HIT_MAX   = Y_W'(HIT_Y_MAX);
    localparam logic [Y_W-1:0]     SPAWN_POS = Y_W'(SPAWN_Y);
    localparam logic [Y_W:0]       BOTTOM    = (Y_W + 1)'(BOTTOM_Y);
    localparam logic [Y_W:0]       STEP      = (Y_W + 1)'(SPEED);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {IDLE, FALL, FLASH} lane_state_t;

    lane_state_t        state     [N_LANES];
    logic [Y_W-1:0]     coin_y    [N_LANES];
    logic [FLASH_W-1:0] flash_cnt [N_LANES];
    logic [Y_W:0]       y_step    [N_LANES];
    logic [N_LANES-1:0] spawn_sel, collect_now, miss_now, lane_cover, lane_visible;
    logic [SCORE_W-1:0] score;
    logic               hit_c;
    logic [7:0]         red_c, green_c, blue_c;

    assign o_score = score;

    always_comb begin
        o_active      = '0;
        o_in_position = '0;
        spawn_sel     = '0;
        collect_now   = '0;
        miss_now      = '0;
        for (int l = 0; l < N_LANES; l++) begin
            o_active[l]      = (state[l] != IDLE);
            o_in_position[l] = (state[l] == FALL) && (coin_y[l] >= HIT_MIN) && (coin_y[l] <= HIT_MAX);
            // one bit wider so a coin near the bottom cannot wrap back to the top
            y_step[l]        = {1'b0, coin_y[l]} + STEP;
            spawn_sel[l]     = (i_spawn_lane == LANE_IDX_W'(l)) && (state[l] == IDLE);
            collect_now[l]   = i_frame_tick && o_in_position[l] && (i_player_lane == LANE_IDX_W'(l));
            miss_now[l]      = i_frame_tick && (state[l] == FALL) && !collect_now[l] && (y_step[l] >= BOTTOM);
        end
        o_spawn_ready = |spawn_sel;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int l = 0; l < N_LANES; l++) begin
                state[l]     <= IDLE;
                coin_y[l]    <= '0;
                flash_cnt[l] <= '0;
            end
            score     <= '0;
            o_collect <= 1'b0;
            o_miss    <= 1'b0;
        end else begin
            o_collect <= |collect_now;
            o_miss    <= |miss_now;
            if (|collect_now && (score != SCORE_MAX)) score <= score + SCORE_W'(1);
            for (int l = 0; l < N_LANES; l++) begin
                case (state[l])
                    IDLE: begin
                        if (i_spawn_valid && spawn_sel[l]) begin
                            state[l]  <= FALL;
                            coin_y[l] <= SPAWN_POS;
                        end
                    end
                    FALL: begin
                        if (collect_now[l]) begin
                            state[l]     <= FLASH;
                            flash_cnt[l] <= FLASH_W'(FLASH_FRAMES);
                        end else if (miss_now[l]) begin
                            state[l]  <= IDLE;
                            coin_y[l] <= '0;
                        end else if (i_frame_tick) begin
                            coin_y[l] <= y_step[l][Y_W-1:0];
                        end
                    end
                    FLASH: begin
                        if (i_frame_tick) begin
                            flash_cnt[l] <= flash_cnt[l] - FLASH_W'(1);
                            if (flash_cnt[l] == FLASH_W'(1)) state[l] <= IDLE;
                        end
                    end
                    default: state[l] <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        lane_cover   = '0;
        lane_visible = '0;
        for (int l = 0; l < N_LANES; l++) begin
            lane_cover[l] = ({1'b0, i_x} >= 17'(LANE_X0 + l * LANE_PITCH))
                         && ({1'b0, i_x} <  17'(LANE_X0 + l * LANE_PITCH + COIN_SIZE))
                         && ({1'b0, i_y} >= 17'(coin_y[l]))
                         && ({1'b0, i_y} <  17'(coin_y[l]) + 17'(COIN_SIZE));
            lane_visible[l] = (state[l] == FALL) || ((state[l] == FLASH) && flash_cnt[l][0]);
        end
    end

    // scanned high to low so the lowest covering lane ends up selected
    always_comb begin
        hit_c   = 1'b0;
        red_c   = 8'h00;
        green_c = 8'h00;
        blue_c  = 8'h00;
        for (int l = N_LANES - 1; l >= 0; l--) begin
            if (lane_cover[l] && lane_visible[l]) begin
                hit_c   = 1'b1;
                red_c   = 8'hFF;
                green_c = (state[l] == FLASH) ? 8'hFF : 8'hD7;
                blue_c  = (state[l] == FLASH) ? 8'hFF : 8'h00;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sprite_hit <= 1'b0;
            o_red        <= 8'h00;
            o_green      <= 8'h00;
            o_blue       <= 8'h00;
        end else begin
            o_sprite_hit <= hit_c;
            o_red        <= red_c;
            o_green      <= green_c;
            o_blue       <= blue_c;
        end
    end

endmodule

// File: tb/tb_coin_lane_manager.sv
// Bench for coin_lane_manager: collect/miss pulses go through a scoreboard queue,
// levels and pixels are checked directly against hand-computed values.
module tb_coin_lane_manager;
    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, spawn_valid;
    logic [1:0]  spawn_lane, player_lane;
    logic        spawn_ready;
    logic [15:0] px, py;
    logic [7:0]  red, green, blue;
    logic        sprite_hit, collect, miss;
    logic [2:0]  in_position, active;
    logic [11:0] score;

    localparam logic [23:0] GOLD  = 24'hFFD700;
    localparam logic [23:0] WHITE = 24'hFFFFFF;

    typedef struct packed {
        logic        is_collect;
        logic [11:0] score;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  errors = 0;
    int  checks = 0;

    coin_lane_manager dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick),
        .i_spawn_valid(spawn_valid), .i_spawn_lane(spawn_lane), .o_spawn_ready(spawn_ready),
        .i_player_lane(player_lane), .i_x(px), .i_y(py),
        .o_red(red), .o_green(green), .o_blue(blue), .o_sprite_hit(sprite_hit),
        .o_in_position(in_position), .o_active(active),
        .o_collect(collect), .o_miss(miss), .o_score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (collect || miss)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: collect=%0b miss=%0b expected none", collect, miss);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", {30'd0, collect, miss}, mon_e.is_collect ? 32'd2 : 32'd1);
                check("event_score", {20'd0, score}, {20'd0, mon_e.score});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic spawn(input logic [1:0] lane, input logic exp_ready);
        spawn_lane  = lane;
        spawn_valid = 1'b1;
        #1;
        check("spawn_ready", {31'd0, spawn_ready}, {31'd0, exp_ready});
        step();
        spawn_valid = 1'b0;
    endtask

    task automatic ready_chk(input logic [1:0] lane, input logic exp_ready);
        spawn_lane = lane;
        #1;
        check("ready_idle", {31'd0, spawn_ready}, {31'd0, exp_ready});
    endtask

    task automatic pix(input int x, input int y, input logic exp_hit, input logic [23:0] exp_rgb);
        px = 16'(x);
        py = 16'(y);
        step();
        check("sprite_hit", {31'd0, sprite_hit}, {31'd0, exp_hit});
        check("rgb", {8'd0, red, green, blue}, {8'd0, exp_rgb});
    endtask

    task automatic push_ev(input logic is_col, input logic [11:0] sc);
        exp_q.push_back('{is_collect: is_col, score: sc});
    endtask

    task automatic drained();
        check("pending_events", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; spawn_lane = 2'd0;
        player_lane = 2'd0; px = 16'd0; py = 16'd0;
        do_reset();

        // reset state
        check("rst_active", {29'd0, active}, 0);
        check("rst_in_pos", {29'd0, in_position}, 0);
        check("rst_score", {20'd0, score}, 0);
        check("rst_pulses", {30'd0, collect, miss}, 0);
        check("rst_hit", {31'd0, sprite_hit}, 0);
        check("rst_rgb", {8'd0, red, green, blue}, 0);

        // 1: lane 1 falls untouched and is missed on the 120th tick (476+4 = 480)
        player_lane = 2'd0;
        spawn(2'd1, 1'b1);
        check("t1_active", {29'd0, active}, 32'b010);
        pix(320, 0, 1'b1, GOLD);
        pix(351, 31, 1'b1, GOLD);
        pix(352, 0, 1'b0, 24'h0);
        pix(320, 32, 1'b0, 24'h0);
        tick(1);
        pix(320, 3, 1'b0, 24'h0);
        pix(320, 4, 1'b1, GOLD);
        tick(98);
        check("t1_pos_396", {29'd0, in_position}, 0);
        tick(1);
        check("t1_pos_400", {29'd0, in_position}, 32'b010);
        tick(10);
        check("t1_pos_440", {29'd0, in_position}, 32'b010);
        tick(1);
        check("t1_pos_444", {29'd0, in_position}, 0);
        tick(8);
        check("t1_active_476", {29'd0, active}, 32'b010);
        push_ev(1'b0, 12'd0);
        tick(1);
        drained();
        check("t1_active_end", {29'd0, active}, 0);
        check("t1_score", {20'd0, score}, 0);
        ready_chk(2'd1, 1'b1);

        // 2: y reaches 400 after 100 ticks; the next tick sees it in the window and collects
        player_lane = 2'd2;
        spawn(2'd2, 1'b1);
        tick(100);
        check("t2_pos", {29'd0, in_position}, 32'b100);
        push_ev(1'b1, 12'd1);
        tick(1);
        drained();
        check("t2_score", {20'd0, score}, 1);
        check("t2_flash_active", {29'd0, active}, 32'b100);
        check("t2_flash_pos", {29'd0, in_position}, 0);
        ready_chk(2'd2, 1'b0);
        pix(480, 400, 1'b0, 24'h0);
        tick(1);
        pix(480, 400, 1'b1, WHITE);
        pix(480, 399, 1'b0, 24'h0);
        tick(6);
        check("t2_flash_last", {29'd0, active}, 32'b100);
        tick(1);
        check("t2_idle", {29'd0, active}, 0);
        ready_chk(2'd2, 1'b1);

        // 3: respawn on a falling lane and out-of-range lane are refused
        spawn(2'd0, 1'b1);
        tick(1);
        spawn(2'd0, 1'b0);
        check("t3_active", {29'd0, active}, 32'b001);
        pix(160, 3, 1'b0, 24'h0);
        pix(160, 4, 1'b1, GOLD);
        spawn(2'd3, 1'b0);
        check("t3_oob_active", {29'd0, active}, 32'b001);
        // out-of-range player lane never collects
        player_lane = 2'd3;
        tick(99);
        check("t3_pos", {29'd0, in_position}, 32'b001);
        tick(1);
        check("t3_nocollect", {29'd0, in_position}, 32'b001);
        check("t3_score", {20'd0, score}, 1);
        do_reset();
        check("t3_reset", {29'd0, active}, 0);

        // 4: spawn coincident with a frame tick does not move in that frame
        player_lane = 2'd2;
        frame_tick = 1'b1;
        spawn(2'd0, 1'b1);
        frame_tick = 1'b0;
        pix(160, 0, 1'b1, GOLD);
        pix(160, 31, 1'b1, GOLD);
        pix(160, 32, 1'b0, 24'h0);
        tick(1);
        pix(160, 3, 1'b0, 24'h0);
        pix(160, 4, 1'b1, GOLD);
        do_reset();

        // 5: score saturation from a preset of 4094
        force dut.score = 12'd4094;
        step();
        release dut.score;
        step();
        check("t5_preset", {20'd0, score}, 4094);
        player_lane = 2'd0;
        spawn(2'd0, 1'b1);
        spawn(2'd1, 1'b1);
        tick(100);
        push_ev(1'b1, 12'd4095);
        tick(1);
        drained();
        player_lane = 2'd1;
        push_ev(1'b1, 12'd4095);
        tick(1);
        drained();
        check("t5_score_sat", {20'd0, score}, 4095);
        check("t5_active", {29'd0, active}, 32'b011);
        tick(8);
        check("t5_idle", {29'd0, active}, 0);
        check("t5_score_hold", {20'd0, score}, 4095);

        // 6: pixel render at y=100, then reset mid-fall clears everything at once
        player_lane = 2'd2;
        spawn(2'd0, 1'b1);
        tick(25);
        pix(170, 110, 1'b1, GOLD);
        pix(200, 110, 1'b0, 24'h0);
        pix(170, 110, 1'b1, GOLD);
        rst = 1'b1;
        #1;
        check("t6_hit", {31'd0, sprite_hit}, 0);
        check("t6_rgb", {8'd0, red, green, blue}, 0);
        check("t6_active", {29'd0, active}, 0);
        check("t6_in_pos", {29'd0, in_position}, 0);
        check("t6_score", {20'd0, score}, 0);
        check("t6_pulses", {30'd0, collect, miss}, 0);
        step();
        rst = 1'b0;
        step();
        drained();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
